// File: rtl/trigger_pkg.sv
// Shared types for the multistage trigger: FSM state encoding and the
// per-stage configuration record.
//
// The stage record is sized for the widest configuration the trigger supports.
// A trigger instance zero-extends its narrower fields into the record on write.
// Zero upper bits never block a match: mask, rise and fall are all zero there.
package trigger_pkg;

    // Widest sample and delay fields a trigger_multistage instance may use
    localparam int TRIG_MAX_SW = 64;
    localparam int TRIG_MAX_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_FIRED = 2'd3
    } trig_state_t;

    typedef struct packed {
        logic [TRIG_MAX_SW-1:0] mask;
        logic [TRIG_MAX_SW-1:0] value;
        logic [TRIG_MAX_SW-1:0] rise;
        logic [TRIG_MAX_SW-1:0] fall;
        logic [TRIG_MAX_DW-1:0] delay;
        logic                   last;
    } stage_cfg_t;

endpackage

// File: rtl/trigger_stage_match.sv
// Match condition for a single trigger stage.
// A stage matches when three things hold:
//   - the masked level compare holds,
//   - every rise bit went 0->1 since the previous valid sample,
//   - every fall bit went 1->0 since the previous valid sample.
// Edge terms cannot be satisfied until a previous sample exists (prev_ok).
module trigger_stage_match
    import trigger_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] prev_sample,
    input  logic                    prev_ok,
    input  logic [TRIG_MAX_SW-1:0]  mask,
    input  logic [TRIG_MAX_SW-1:0]  value,
    input  logic [TRIG_MAX_SW-1:0]  rise,
    input  logic [TRIG_MAX_SW-1:0]  fall,
    output logic                    hit
);

    logic [TRIG_MAX_SW-1:0] now_w;
    logic [TRIG_MAX_SW-1:0] prev_w;
    logic [TRIG_MAX_SW-1:0] level_err;
    logic [TRIG_MAX_SW-1:0] rise_err;
    logic [TRIG_MAX_SW-1:0] fall_err;
    logic                   edge_req;

    // Widen both samples, then collect per-bit violations of each term
    always_comb begin
        now_w     = TRIG_MAX_SW'(sample);
        prev_w    = TRIG_MAX_SW'(prev_sample);
        level_err = (now_w ^ value) & mask;
        rise_err  = rise & ~(~prev_w & now_w);
        fall_err  = fall & ~(prev_w & ~now_w);
        edge_req  = |(rise | fall);
        hit       = (level_err == '0) && (rise_err == '0) && (fall_err == '0)
                    && (!edge_req || prev_ok);
    end

endmodule

// File: rtl/trigger_multistage.sv
// Serial multistage logic-analyser trigger.
// Stages are searched in order. After each stage matches, the trigger waits
// for that stage's delay, counted in valid samples, before moving on. When the
// final stage completes, run is raised and held until the next arm or disarm.
module trigger_multistage
    import trigger_pkg::*;
#(
    parameter  int SAMPLE_WIDTH = 8,
    parameter  int NUM_STAGES   = 4,
    parameter  int DELAY_WIDTH  = 16,
    localparam int IDX_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_stage,
    input  logic [SAMPLE_WIDTH-1:0] cfg_mask,
    input  logic [SAMPLE_WIDTH-1:0] cfg_value,
    input  logic [SAMPLE_WIDTH-1:0] cfg_rise,
    input  logic [SAMPLE_WIDTH-1:0] cfg_fall,
    input  logic [DELAY_WIDTH-1:0]  cfg_delay,
    input  logic                    cfg_last,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    output logic                    run,
    output logic                    armed,
    output logic [IDX_W-1:0]        stage_idx
);

    trig_state_t             state_reg, state_next;
    logic [IDX_W-1:0]        stage_idx_reg, stage_idx_next;
    logic [DELAY_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [SAMPLE_WIDTH-1:0] prev_reg;
    logic                    prev_ok_reg;

    stage_cfg_t              cfg_tbl [NUM_STAGES];
    stage_cfg_t              cfg_wr_word;
    stage_cfg_t              cur_cfg;
    logic                    cfg_sel_ok;
    logic                    cfg_wr_ok;

    logic                    stage_hit;
    logic                    final_stage;
    logic                    delay_zero;
    logic                    advance;

    // ------------------------------------------------------------------
    // Stage configuration storage
    // ------------------------------------------------------------------

    // Out-of-range stage numbers only exist when NUM_STAGES is not a power of two
    if ((1 << IDX_W) == NUM_STAGES) begin : g_sel_full
        assign cfg_sel_ok = 1'b1;
    end else begin : g_sel_range
        assign cfg_sel_ok = (int'(cfg_stage) < NUM_STAGES);
    end

    // Config may only change while no search is running
    assign cfg_wr_ok = cfg_we && cfg_sel_ok
                       && ((state_reg == ST_IDLE) || (state_reg == ST_FIRED));

    // Zero-extend the write fields into the shared stage record
    always_comb begin
        cfg_wr_word       = '0;
        cfg_wr_word.mask  = TRIG_MAX_SW'(cfg_mask);
        cfg_wr_word.value = TRIG_MAX_SW'(cfg_value);
        cfg_wr_word.rise  = TRIG_MAX_SW'(cfg_rise);
        cfg_wr_word.fall  = TRIG_MAX_SW'(cfg_fall);
        cfg_wr_word.delay = TRIG_MAX_DW'(cfg_delay);
        cfg_wr_word.last  = cfg_last;
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        stage_cfg_t cfg_reg;

        // One config register per stage, written when addressed
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cfg_reg <= '0;
            end else if (cfg_wr_ok && (cfg_stage == IDX_W'(gi))) begin
                cfg_reg <= cfg_wr_word;
            end
        end

        assign cfg_tbl[gi] = cfg_reg;
    end

    assign cur_cfg = cfg_tbl[stage_idx_reg];

    // ------------------------------------------------------------------
    // Match logic on the current stage only
    // ------------------------------------------------------------------

    trigger_stage_match #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_match (
        .sample      (data_in),
        .prev_sample (prev_reg),
        .prev_ok     (prev_ok_reg),
        .mask        (cur_cfg.mask),
        .value       (cur_cfg.value),
        .rise        (cur_cfg.rise),
        .fall        (cur_cfg.fall),
        .hit         (stage_hit)
    );

    // The stored delay upper bits are always zero, so a full compare is exact
    assign delay_zero  = (cur_cfg.delay == '0);
    assign final_stage = cur_cfg.last || (int'(stage_idx_reg) == NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // Previous-sample tracking for edge terms
    // ------------------------------------------------------------------

    // prev follows every valid sample; prev_ok marks it as belonging to this search
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg    <= '0;
            prev_ok_reg <= 1'b0;
        end else begin
            if (valid) begin
                prev_reg <= data_in;
            end
            if (arm) begin
                prev_ok_reg <= 1'b0;
            end else if (valid) begin
                prev_ok_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Search FSM
    // ------------------------------------------------------------------

    // State, stage pointer and delay counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            stage_idx_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            stage_idx_reg <= stage_idx_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Next state: disarm beats arm, arm beats any search progress
    always_comb begin
        state_next     = state_reg;
        stage_idx_next = stage_idx_reg;
        cnt_next       = cnt_reg;
        advance        = 1'b0;

        if (disarm) begin
            state_next     = ST_IDLE;
            stage_idx_next = '0;
            cnt_next       = '0;
        end else if (arm) begin
            state_next     = ST_ARMED;
            stage_idx_next = '0;
            cnt_next       = '0;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (valid && stage_hit) begin
                        if (delay_zero) begin
                            advance = 1'b1;
                        end else begin
                            state_next = ST_DELAY;
                            cnt_next   = cur_cfg.delay[DELAY_WIDTH-1:0];
                        end
                    end
                end
                ST_DELAY: begin
                    if (valid) begin
                        if (cnt_reg == DELAY_WIDTH'(1)) begin
                            advance = 1'b1;
                        end else begin
                            cnt_next = cnt_reg - DELAY_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and FIRED wait for arm/disarm
                end
            endcase

            if (advance) begin
                cnt_next = '0;
                if (final_stage) begin
                    state_next = ST_FIRED;
                end else begin
                    state_next     = ST_ARMED;
                    stage_idx_next = stage_idx_reg + IDX_W'(1);
                end
            end
        end
    end

    assign run       = (state_reg == ST_FIRED);
    assign armed     = (state_reg == ST_ARMED) || (state_reg == ST_DELAY);
    assign stage_idx = stage_idx_reg;

endmodule

// File: tb/tb_trigger_multistage.sv
// Bench for trigger_multistage: directed scenarios plus a randomized phase,
// all checked against a sequential reference model of the trigger rules.
module tb_trigger_multistage;

    localparam int SW = 8;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_stage = '0;
    logic [SW-1:0] cfg_mask = '0;
    logic [SW-1:0] cfg_value = '0;
    logic [SW-1:0] cfg_rise = '0;
    logic [SW-1:0] cfg_fall = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_last = 1'b0;
    logic          arm = 1'b0;
    logic          disarm = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] data_in = '0;
    logic          run;
    logic          armed;
    logic [IW-1:0] stage_idx;

    always #5 clock = ~clock;

    trigger_multistage #(
        .SAMPLE_WIDTH (SW),
        .NUM_STAGES   (NS),
        .DELAY_WIDTH  (DW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_stage (cfg_stage),
        .cfg_mask  (cfg_mask),
        .cfg_value (cfg_value),
        .cfg_rise  (cfg_rise),
        .cfg_fall  (cfg_fall),
        .cfg_delay (cfg_delay),
        .cfg_last  (cfg_last),
        .arm       (arm),
        .disarm    (disarm),
        .valid     (valid),
        .data_in   (data_in),
        .run       (run),
        .armed     (armed),
        .stage_idx (stage_idx)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    string cur_tag = "reset";

    // Reference model: mode 0 idle, 1 searching, 2 waiting out delay, 3 fired
    logic [SW-1:0] m_mask  [NS];
    logic [SW-1:0] m_value [NS];
    logic [SW-1:0] m_rise  [NS];
    logic [SW-1:0] m_fall  [NS];
    int            m_delay [NS];
    bit            m_last  [NS];
    int            m_mode;
    int            m_stage;
    int            m_left;
    logic [SW-1:0] m_prev;
    bit            m_prev_ok;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", cur_tag, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_mask[s] = '0; m_value[s] = '0; m_rise[s] = '0; m_fall[s] = '0;
            m_delay[s] = 0; m_last[s] = 1'b0;
        end
        m_mode = 0; m_stage = 0; m_left = 0; m_prev = '0; m_prev_ok = 1'b0;
    endtask

    function automatic bit model_match();
        bit ok;
        int s = m_stage;
        ok = (((data_in ^ m_value[s]) & m_mask[s]) == '0);
        for (int b = 0; b < SW; b++) begin
            if (m_rise[s][b] && !(m_prev_ok && !m_prev[b] && data_in[b])) ok = 1'b0;
            if (m_fall[s][b] && !(m_prev_ok && m_prev[b] && !data_in[b])) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_finish();
        if (m_last[m_stage] || m_stage == NS - 1) begin
            m_mode = 3;
        end else begin
            m_stage = m_stage + 1;
            m_mode  = 1;
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are compared
    task automatic step();
        bit hit;
        @(posedge clock);
        hit = model_match();
        if (cfg_we && (m_mode == 0 || m_mode == 3) && int'(cfg_stage) < NS) begin
            m_mask[cfg_stage]  = cfg_mask;
            m_value[cfg_stage] = cfg_value;
            m_rise[cfg_stage]  = cfg_rise;
            m_fall[cfg_stage]  = cfg_fall;
            m_delay[cfg_stage] = int'(cfg_delay);
            m_last[cfg_stage]  = cfg_last;
        end
        if (disarm) begin
            m_mode = 0; m_stage = 0; m_left = 0;
        end else if (arm) begin
            m_mode = 1; m_stage = 0; m_left = 0;
        end else if (m_mode == 1 && valid && hit) begin
            if (m_delay[m_stage] == 0) model_finish();
            else begin
                m_mode = 2;
                m_left = m_delay[m_stage];
            end
        end else if (m_mode == 2 && valid) begin
            m_left = m_left - 1;
            if (m_left == 0) model_finish();
        end
        if (valid) m_prev = data_in;
        if (arm) m_prev_ok = 1'b0;
        else if (valid) m_prev_ok = 1'b1;
        #1;
        arm = 1'b0; disarm = 1'b0; valid = 1'b0; cfg_we = 1'b0;
        check("run", 32'(run), 32'(m_mode == 3));
        check("armed", 32'(armed), 32'(m_mode == 1 || m_mode == 2));
        check("stage_idx", 32'(stage_idx), 32'(m_stage));
    endtask

    task automatic wcfg(int s, logic [SW-1:0] mk, logic [SW-1:0] val,
                        logic [SW-1:0] ri, logic [SW-1:0] fa, int dl, bit ls);
        cfg_we = 1'b1; cfg_stage = IW'(s); cfg_mask = mk; cfg_value = val;
        cfg_rise = ri; cfg_fall = fa; cfg_delay = DW'(dl); cfg_last = ls;
        step();
    endtask

    task automatic smp(logic [SW-1:0] d);
        valid = 1'b1; data_in = d;
        step();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_run", 32'(run), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_stage", 32'(stage_idx), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Single level stage on A5
        cur_tag = "level";
        wcfg(0, 8'hFF, 8'hA5, 8'h00, 8'h00, 0, 1'b1);
        do_arm();
        check("armed_after_arm", 32'(armed), 32'd1);
        smp(8'h00);
        check("run_before", 32'(run), 32'd0);
        smp(8'hA5);
        check("run_after_a5", 32'(run), 32'd1);
        step();
        check("run_held", 32'(run), 32'd1);

        // Rising edge stage then level stage
        cur_tag = "two_stage";
        do_disarm();
        wcfg(0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1'b0);
        wcfg(1, 8'h80, 8'h80, 8'h00, 8'h00, 0, 1'b1);
        do_arm();
        smp(8'h00);
        check("stage0", 32'(stage_idx), 32'd0);
        smp(8'h01);
        check("stage1", 32'(stage_idx), 32'd1);
        smp(8'h00);
        check("run_mid", 32'(run), 32'd0);
        smp(8'h80);
        check("run_end", 32'(run), 32'd1);

        // Post-match delay of 3 valid samples with gaps
        cur_tag = "delay";
        do_disarm();
        wcfg(0, 8'hFF, 8'h11, 8'h00, 8'h00, 3, 1'b1);
        do_arm();
        smp(8'h11);
        check("in_delay", 32'(armed), 32'd1);
        step();
        smp(8'h00);
        step();
        smp(8'h00);
        check("run_after2", 32'(run), 32'd0);
        step();
        check("run_gap", 32'(run), 32'd0);
        smp(8'h00);
        check("run_after3", 32'(run), 32'd1);

        // Edge term needs a previous sample from this search
        cur_tag = "edge_first";
        wcfg(0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1'b1);
        do_arm();
        smp(8'h01);
        check("no_match_first", 32'(run), 32'd0);
        smp(8'h00);
        smp(8'h01);
        check("match_edge", 32'(run), 32'd1);

        // arm+disarm together, disarm during delay, config write while armed
        cur_tag = "abort";
        arm = 1'b1; disarm = 1'b1;
        step();
        check("both_idle", 32'(armed), 32'd0);
        wcfg(0, 8'hFF, 8'h11, 8'h00, 8'h00, 5, 1'b1);
        do_arm();
        smp(8'h11);
        check("delay_armed", 32'(armed), 32'd1);
        do_disarm();
        check("disarm_armed", 32'(armed), 32'd0);
        repeat (6) smp(8'h11);
        check("disarm_run", 32'(run), 32'd0);
        wcfg(0, 8'hFF, 8'h22, 8'h00, 8'h00, 0, 1'b1);
        do_arm();
        wcfg(0, 8'hFF, 8'h33, 8'h00, 8'h00, 0, 1'b1);
        smp(8'h33);
        check("ignored_cfg", 32'(run), 32'd0);
        smp(8'h22);
        check("kept_cfg", 32'(run), 32'd1);

        // All four stages without cfg_last
        cur_tag = "four_stage";
        for (int s = 0; s < NS; s++) wcfg(s, 8'hFF, 8'(s + 1), 8'h00, 8'h00, 0, 1'b0);
        do_arm();
        smp(8'h01);
        smp(8'h02);
        smp(8'h03);
        check("at_stage3", 32'(stage_idx), 32'd3);
        check("not_yet", 32'(run), 32'd0);
        smp(8'h04);
        check("fired", 32'(run), 32'd1);

        // Asynchronous reset during a delay
        cur_tag = "async_reset";
        wcfg(0, 8'hFF, 8'h01, 8'h00, 8'h00, 10, 1'b0);
        do_arm();
        smp(8'h01);
        check("pre_armed", 32'(armed), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("run0", 32'(run), 32'd0);
        check("armed0", 32'(armed), 32'd0);
        check("stage0", 32'(stage_idx), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        // Cleared configs match any sample, so four samples walk all stages
        do_arm();
        smp(8'h5A);
        smp(8'hC3);
        smp(8'h00);
        check("zero_cfg_not_yet", 32'(run), 32'd0);
        smp(8'hFF);
        check("zero_cfg_fired", 32'(run), 32'd1);

        // Randomized traffic against the model
        cur_tag = "random";
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 4) arm = 1'b1;
            else if (r < 6) disarm = 1'b1;
            else if (r < 7) begin arm = 1'b1; disarm = 1'b1; end
            if ($urandom_range(9) == 0) begin
                cfg_we    = 1'b1;
                cfg_stage = IW'($urandom_range(NS - 1));
                cfg_mask  = SW'($urandom & $urandom);
                cfg_value = SW'($urandom);
                cfg_rise  = ($urandom_range(3) == 0) ? SW'(1 << $urandom_range(SW - 1)) : '0;
                cfg_fall  = ($urandom_range(3) == 0) ? SW'(1 << $urandom_range(SW - 1)) : '0;
                cfg_delay = DW'($urandom_range(3));
                cfg_last  = ($urandom_range(3) == 0);
            end
            valid   = ($urandom_range(3) != 0);
            data_in = SW'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
